// File: rtl/turn_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turn_match_ctrl
// Brief    : Memory-match turn/pair controller: picks, reveal selects, pair
//            comparison, per-player scores and per-turn timeout.
// Revision : 1.0
// ============================================================================
module turn_match_ctrl #(
    parameter int N_CELLS     = 16,
    parameter int SHOW_CYCLES = 50,
    parameter int TURN_CYCLES = 1000
) (
    input  logic               clk_Temp,
    input  logic               rst,
    input  logic               pick,
    input  logic [3:0]         cursor,
    input  logic [3:0]         cell_label,
    input  logic               cell_open,
    output logic [N_CELLS-1:0] select,
    output logic               par,
    output logic               player,
    output logic               counter,
    output logic [3:0]         score0,
    output logic [3:0]         score1,
    output logic               game_over
);

    localparam int TW = $clog2(TURN_CYCLES);
    localparam int SW = $clog2(SHOW_CYCLES + 1);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [SW-1:0]      SHOW_LAST  = SW'(SHOW_CYCLES - 1);
    localparam logic [3:0]         ALL_PAIRS  = 4'(N_CELLS / 2);
    localparam logic [4:0]         CELL_LIMIT = 5'(N_CELLS);
    localparam logic [N_CELLS-1:0] SEL_ONE    = {{(N_CELLS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_FIRST  = 3'd0,
        ST_SECOND = 3'd1,
        ST_CMP    = 3'd2,
        ST_MATCH  = 3'd3,
        ST_SHOW   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t             state_q,   state_d;
    logic [N_CELLS-1:0] select_q,  select_d;
    logic               counter_q, counter_d;
    logic               player_q,  player_d;
    logic [3:0]         score0_q,  score0_d;
    logic [3:0]         score1_q,  score1_d;
    logic [3:0]         pairs_q,   pairs_d;
    logic [TW-1:0]      timer_q,   timer_d;
    logic [SW-1:0]      show_q,    show_d;
    logic [3:0]         idx_a_q,   idx_a_d;
    logic [3:0]         label_a_q, label_a_d;
    logic [3:0]         label_b_q, label_b_d;

    logic               w_valid;
    logic               w_timeout;
    logic [N_CELLS-1:0] w_hit;

    assign w_valid   = pick && !cell_open && ({1'b0, cursor} < CELL_LIMIT);
    assign w_hit     = SEL_ONE << cursor;
    assign w_timeout = ((state_q == ST_FIRST) || (state_q == ST_SECOND)) &&
                       (timer_q == TIMER_LAST);

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        player_d  = player_q;
        score0_d  = score0_q;
        score1_d  = score1_q;
        pairs_d   = pairs_q;
        timer_d   = timer_q;
        show_d    = show_q;
        idx_a_d   = idx_a_q;
        label_a_d = label_a_q;
        label_b_d = label_b_q;

        case (state_q)
            ST_FIRST, ST_SECOND: begin
                // Timeout has priority over a pick arriving on the same edge
                if (w_timeout) begin
                    select_d = '0;
                    timer_d  = '0;
                    player_d = ~player_q;
                    state_d  = ST_FIRST;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (state_q == ST_FIRST && w_valid) begin
                        idx_a_d   = cursor;
                        label_a_d = cell_label;
                        select_d  = w_hit;
                        state_d   = ST_SECOND;
                    end else if (state_q == ST_SECOND && w_valid && cursor != idx_a_q) begin
                        label_b_d = cell_label;
                        select_d  = select_q | w_hit;
                        state_d   = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                timer_d = '0;
                show_d  = '0;
                state_d = (label_a_q == label_b_q) ? ST_MATCH : ST_SHOW;
            end
            ST_MATCH: begin
                select_d = '0;
                if (!player_q) begin
                    score0_d = (score0_q == 4'hF) ? score0_q : score0_q + 4'd1;
                end else begin
                    score1_d = (score1_q == 4'hF) ? score1_q : score1_q + 4'd1;
                end
                pairs_d = pairs_q + 4'd1;
                state_d = (pairs_d == ALL_PAIRS) ? ST_OVER : ST_FIRST;
            end
            ST_SHOW: begin
                if (show_q == SHOW_LAST) begin
                    select_d = '0;
                    player_d = ~player_q;
                    show_d   = '0;
                    state_d  = ST_FIRST;
                end else begin
                    show_d = show_q + SW'(1);
                end
            end
            ST_OVER: begin
                select_d = '0;
            end
            default: begin
                select_d = '0;
                state_d  = ST_FIRST;
            end
        endcase

        // Registered so it reads 0 while reset is asserted
        counter_d = (state_d == ST_FIRST) || (state_d == ST_SECOND);
    end

    always_ff @(posedge clk_Temp or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FIRST;
            select_q  <= '0;
            counter_q <= 1'b0;
            player_q  <= 1'b0;
            score0_q  <= '0;
            score1_q  <= '0;
            pairs_q   <= '0;
            timer_q   <= '0;
            show_q    <= '0;
            idx_a_q   <= '0;
            label_a_q <= '0;
            label_b_q <= '0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            counter_q <= counter_d;
            player_q  <= player_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            pairs_q   <= pairs_d;
            timer_q   <= timer_d;
            show_q    <= show_d;
            idx_a_q   <= idx_a_d;
            label_a_q <= label_a_d;
            label_b_q <= label_b_d;
        end
    end

    assign select    = select_q;
    assign par       = (state_q == ST_MATCH);
    assign player    = player_q;
    assign counter   = counter_q;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign game_over = (state_q == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_turn_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_match_ctrl
// Brief    : Directed table, corner sequences and random play for
//            turn_match_ctrl against a turn-level reference model.
// Revision : 1.0
// ============================================================================
module tb_turn_match_ctrl;

    localparam int N = 8;
    localparam int S = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pick = 1'b0;
    logic         cell_open = 1'b0;
    logic [3:0]   cursor = 4'd0;
    logic [3:0]   cell_label = 4'd0;
    logic [N-1:0] select;
    logic         par, player, counter, game_over;
    logic [3:0]   score0, score1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    turn_match_ctrl #(.N_CELLS(N), .SHOW_CYCLES(S), .TURN_CYCLES(T)) dut (
        .clk_Temp   (clk),
        .rst        (rst_n),
        .pick       (pick),
        .cursor     (cursor),
        .cell_label (cell_label),
        .cell_open  (cell_open),
        .select     (select),
        .par        (par),
        .player     (player),
        .counter    (counter),
        .score0     (score0),
        .score1     (score1),
        .game_over  (game_over)
    );

    // Reference model: a turn is "picking" until two distinct cells are chosen,
    // after which a fixed number of reveal cycles elapse before it resolves.
    logic [N-1:0] m_sel;
    bit           m_player, m_over, m_match, m_par, m_counter;
    int           m_pairs, m_timer, m_post, m_first, m_lbl_a;
    int           m_score[2];

    task automatic m_reset();
        m_sel = '0; m_player = 0; m_over = 0; m_match = 0; m_par = 0; m_counter = 0;
        m_pairs = 0; m_timer = 0; m_post = 0; m_first = -1; m_lbl_a = 0;
        m_score[0] = 0; m_score[1] = 0;
    endtask

    task automatic m_step(input bit p, input int cur, input int lbl, input bit o);
        m_par = 0;
        if (m_over) begin
            m_sel = '0;
        end else if (m_post > 0) begin
            m_post--;
            if (m_post == 1 && m_match) m_par = 1;
            if (m_post == 0) begin
                m_sel = '0;
                if (m_match) begin
                    m_score[m_player] = (m_score[m_player] < 15) ? m_score[m_player] + 1 : 15;
                    m_pairs++;
                    if (m_pairs == N / 2) m_over = 1;
                end else begin
                    m_player = !m_player;
                end
            end
        end else if (m_timer == T - 1) begin
            m_sel = '0; m_timer = 0; m_first = -1; m_player = !m_player;
        end else begin
            m_timer++;
            if (p && !o && cur < N) begin
                if (m_first < 0) begin
                    m_first = cur; m_lbl_a = lbl; m_sel[cur] = 1'b1;
                end else if (cur != m_first) begin
                    m_sel[cur] = 1'b1;
                    m_match = (lbl == m_lbl_a);
                    m_post = m_match ? 2 : 1 + S;
                    m_timer = 0; m_first = -1;
                end
            end
        end
        m_counter = !m_over && (m_post == 0);
    endtask

    function automatic logic [31:0] dut_vec();
        return {12'd0, select, par, player, counter, score0, score1, game_over};
    endfunction

    function automatic logic [31:0] mdl_vec();
        return {12'd0, m_sel, m_par, m_player, m_counter,
                4'(m_score[0]), 4'(m_score[1]), m_over};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, let one edge pass, compare to model
    task automatic step(input bit p, input int cur, input int lbl, input bit o);
        pick = p; cursor = 4'(cur); cell_label = 4'(lbl); cell_open = o;
        @(posedge clk); #1;
        m_step(p, cur, lbl, o);
        check("model", dut_vec(), mdl_vec());
    endtask

    task automatic do_reset();
        pick = 1'b0;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("reset", dut_vec(), mdl_vec());
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       p;
        logic [3:0] c;
        logic [3:0] l;
        logic       o;
        logic [7:0] sel;
        logic       pr;
        logic       ply;
        logic       cnt;
        logic [3:0] s0;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [3:0] c, input logic [3:0] l,
                                input logic o, input logic [7:0] sel, input logic pr,
                                input logic ply, input logic cnt, input logic [3:0] s0);
        vec_t v;
        v.p = p; v.c = c; v.l = l; v.o = o; v.sel = sel;
        v.pr = pr; v.ply = ply; v.cnt = cnt; v.s0 = s0;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // match with illegal picks in SECOND, mismatch with SHOW hold, timeout
        tbl[0]  = mk(1'b1, 4'd3, 4'd5, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[1]  = mk(1'b1, 4'd3, 4'd5, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[2]  = mk(1'b1, 4'd9, 4'd5, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[3]  = mk(1'b1, 4'd5, 4'd5, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 4'd0);
        tbl[4]  = mk(1'b1, 4'd6, 4'd5, 1'b0, 8'h48, 1'b0, 1'b0, 1'b0, 4'd0);
        tbl[5]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h48, 1'b1, 1'b0, 1'b0, 4'd0);
        tbl[6]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
        tbl[7]  = mk(1'b1, 4'd1, 4'd2, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 4'd1);
        tbl[8]  = mk(1'b1, 4'd4, 4'd5, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[9]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[10] = mk(1'b1, 4'd7, 4'd2, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[11] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[12] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'd1);
        tbl[13] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[14] = mk(1'b1, 4'd2, 4'd7, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[15] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[16] = mk(1'b1, 4'd2, 4'd7, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[17] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[18] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[19] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[20] = mk(1'b0, 4'd0, 4'd0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 4'd1);
        tbl[21] = mk(1'b1, 4'd0, 4'd7, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
        tbl[22] = mk(1'b1, 4'd12, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);

        #1;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].p, int'(tbl[i].c), int'(tbl[i].l), tbl[i].o);
            check($sformatf("tbl[%0d]", i),
                  {15'd0, select, par, player, counter, score0},
                  {15'd0, tbl[i].sel, tbl[i].pr, tbl[i].ply, tbl[i].cnt, tbl[i].s0});
        end

        // Player 1 scores, then reset asynchronously in the middle of SHOW
        do_reset();
        repeat (T) step(0, 0, 0, 0);
        check("timeout_player", {31'd0, player}, 32'd1);
        step(1, 0, 1, 0); step(1, 1, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("p1_match", {27'd0, player, score1}, {27'd0, 1'b1, 4'd1});
        step(1, 2, 1, 0); step(1, 3, 2, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        check("show_sel", {24'd0, select}, 32'h0000_000C);
        rst_n = 1'b0;
        #2;
        check("async_rst", {18'd0, select, player, counter, score0, score1}, 32'd0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full game by player 0
        for (int k = 0; k < N / 2; k++) begin
            step(1, 2 * k, k, 0); step(1, 2 * k + 1, k, 0);
            step(0, 0, 0, 0); step(0, 0, 0, 0);
            if (k == N / 2 - 2) check("not_over_yet", {31'd0, game_over}, 32'd0);
        end
        check("game_over", {27'd0, game_over, score0}, {27'd0, 1'b1, 4'd4});
        for (int k = 0; k < 3; k++) begin
            step(1, k, 9, 0);
            check("over_idle", {22'd0, select, counter, game_over}, {22'd0, 8'h00, 1'b0, 1'b1});
        end

        // Random play against the model, with occasional resets
        do_reset();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
